pipe_skid_buffer: RTL
=====================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 Parameter DATA_W, default 69, SHALL set the datapath payload width (ALU result 32 + store data 32 + destination register 5).
REQ-002 Parameter CTRL_W, default 5, SHALL set the control-field width (reg write, mem-to-reg, mem write, mem read, branch enable).
REQ-003 Parameter RST_VAL, default 0, SHALL give the reset and bubble value of the payload registers (DATA_W wide).
REQ-004 Port clk, input, 1, SHALL be the clock; reset is asynchronous, active-high, and all state changes happen on the rising edge of clk.
REQ-005 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port in_valid, input, 1, SHALL mark the upstream (EX) beat as valid.
REQ-007 Port in_ready, output, 1, SHALL indicate that the buffer accepts a beat in this cycle.
REQ-008 Port in_ctrl, input, CTRL_W, SHALL carry the upstream control field.
REQ-009 Port in_data, input, DATA_W, SHALL carry the upstream payload.
REQ-010 Port out_valid, output, 1, SHALL mark the downstream (MEM) beat as valid.
REQ-011 Port out_ready, input, 1, SHALL be the downstream accept signal.
REQ-012 Port out_ctrl, output, CTRL_W, SHALL carry the downstream control field.
REQ-013 Port out_data, output, DATA_W, SHALL carry the downstream payload.
REQ-014 Port flush, input, 1, SHALL be the pipeline kill request; it is present only under PIPE_BUF_FLUSH_EN.
REQ-015 Port occupancy, output, 2, SHALL report the number of held entries (0–2).

Function
REQ-016 Storage SHALL be a 2-entry skid buffer with a main register (drives the outputs) and a skid register, under an FSM with states EMPTY, ONE and FULL.
REQ-017 A transfer SHALL occur only when valid and ready are both 1 on the same edge; in_ready SHALL be a registered signal equal to (state != FULL).
REQ-018 Latency SHALL be 1 cycle: a beat accepted into EMPTY SHALL appear on out_* at the next edge.
REQ-019 EMPTY SHALL go to ONE on an input accept.
REQ-020 ONE SHALL stay in ONE on a simultaneous input accept and output accept, and the main register SHALL take the new beat.
REQ-021 ONE SHALL go to FULL on an input accept with out_ready=0, and the beat SHALL go to the skid register.
REQ-022 ONE SHALL go to EMPTY on an output accept with no input.
REQ-023 FULL SHALL go to ONE on an output accept, and the skid register SHALL move to the main register.
REQ-024 FULL SHALL hold on out_ready=0.
REQ-025 Beat ordering SHALL be strict FIFO, with no loss or duplication.
REQ-026 out_ctrl SHALL be forced to all-zero whenever out_valid=0, so that a bubble cannot write a register or memory.
REQ-027 When out_valid=1 and out_ready=0, out_ctrl and out_data SHALL stay stable.
REQ-028 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-029 Asserting reset SHALL asynchronously force the state to EMPTY, out_valid=0, in_ready=0, out_ctrl=0, out_data=RST_VAL, the skid register to RST_VAL and occupancy=0.
REQ-030 On the first edge after reset deasserts, in_ready SHALL become 1.
REQ-031 Reset asserted mid-transfer SHALL discard all held beats.

Configuration
REQ-032 With PIPE_BUF_FLUSH_EN defined, flush=1 at an edge SHALL empty both entries, and the state SHALL become EMPTY.
REQ-033 With PIPE_BUF_FLUSH_EN defined, flush SHALL take priority over a simultaneous input accept, and that beat SHALL be dropped.
REQ-034 With PIPE_BUF_FLUSH_EN defined, in_ready SHALL be 1 in the cycle after a flush.
REQ-035 With PIPE_BUF_FLUSH_EN undefined, the flush port and its logic SHALL be absent, and the behaviour SHALL be otherwise identical.

Structure
REQ-036 The shared package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/FULL), the CTRL_W default, and named bit indices for the control field (CTRL_REG_WR, CTRL_MEM2REG, CTRL_MEM_WR, CTRL_MEM_RD, CTRL_BRANCH).
REQ-037 A single sub-module pipe_stage_reg SHALL implement one reset-able, load-enabled {valid, ctrl, data} register, instanced twice (main and skid).

Verification
REQ-038 Reset with DATA_W=69: in_valid=1 held during reset -> out_valid=0, out_ctrl=0, occupancy=0, and in_ready=1 one edge after deassert.
REQ-039 Streaming: out_ready=1, beats 0x1..0x8 on consecutive cycles -> out_data shows 0x1..0x8 each one cycle later, and occupancy never exceeds 1.
REQ-040 Backpressure: out_ready=0 and beats 0xA, 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xA then 0xB, in order, with no duplicates.
REQ-041 Simultaneous events in ONE: in_valid=1 with out_ready=1 for 4 cycles -> state stays ONE and throughput is 1 beat per cycle.
REQ-042 Flush (PIPE_BUF_FLUSH_EN defined): FULL plus flush=1 with in_valid=1 (beat 0xC) -> occupancy=0, out_ctrl=0 next cycle, and 0xC is never output.
REQ-043 Random valid/ready for 10k cycles -> a scoreboard matches every beat in order, and out_ctrl is 0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM skid buffer: buffer state encoding,
// default control width and bit positions inside the control field.
// Optional feature macro used by pipe_skid_buffer: PIPE_BUF_FLUSH_EN.
package pipe_pkg;

    // Number of buffered entries held by the skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Default control-field width: reg write, mem-to-reg, mem write, mem read, branch
    localparam int CTRL_W_DEFAULT = 5;

    // Bit positions of the individual control flags
    localparam int CTRL_BRANCH  = 0;
    localparam int CTRL_MEM_RD  = 1;
    localparam int CTRL_MEM_WR  = 2;
    localparam int CTRL_MEM2REG = 3;
    localparam int CTRL_REG_WR  = 4;

    // Maps a buffer state onto the count of held entries
    function automatic logic [1:0] state_occupancy(input buf_state_t s);
        case (s)
            EMPTY:   state_occupancy = 2'd0;
            ONE:     state_occupancy = 2'd1;
            FULL:    state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One {valid, ctrl, data} pipeline register with asynchronous reset and a
// load enable. The skid buffer instances it twice (main and skid entry).
// Optional feature macro of the enclosing design: PIPE_BUF_FLUSH_EN (unused here).
module pipe_stage_reg #(
    parameter int                 DATA_W  = 69,
    parameter int                 CTRL_W  = 5,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              next_valid,
    input  logic [CTRL_W-1:0] next_ctrl,
    input  logic [DATA_W-1:0] next_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Capture a new entry when loaded; reset returns the entry to a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= RST_VAL;
        end else if (load) begin
            valid <= next_valid;
            ctrl  <= next_ctrl;
            data  <= next_data;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between EX and MEM. The main entry drives the
// outputs; the skid entry catches a beat accepted while MEM is stalled so
// that in_ready can be registered without losing data.
// Optional feature macro: PIPE_BUF_FLUSH_EN adds the flush (pipeline kill) port.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int                 DATA_W  = 69,
    parameter int                 CTRL_W  = CTRL_W_DEFAULT,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_BUF_FLUSH_EN
    input  logic              flush,
`endif
    output logic [1:0]        occupancy
);

    buf_state_t        state;
    buf_state_t        next_state;

    logic              in_accept;
    logic              out_accept;

    logic              main_load;
    logic              main_next_valid;
    logic [CTRL_W-1:0] main_next_ctrl;
    logic [DATA_W-1:0] main_next_data;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    logic              skid_load;
    logic              skid_next_valid;
    logic [CTRL_W-1:0] skid_next_ctrl;
    logic [DATA_W-1:0] skid_next_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_accept  = in_valid & in_ready;
    assign out_accept = main_valid & out_ready;

    // Main entry: the beat currently presented to MEM
    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .load       (main_load),
        .next_valid (main_next_valid),
        .next_ctrl  (main_next_ctrl),
        .next_data  (main_next_data),
        .valid      (main_valid),
        .ctrl       (main_ctrl),
        .data       (main_data)
    );

    // Skid entry: the second beat held while MEM stalls
    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .next_valid (skid_next_valid),
        .next_ctrl  (skid_next_ctrl),
        .next_data  (skid_next_data),
        .valid      (skid_valid),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
    );

    // Next state and entry steering; a load without a new beat writes a bubble
    always_comb begin
        next_state      = state;
        main_load       = 1'b0;
        main_next_valid = 1'b0;
        main_next_ctrl  = '0;
        main_next_data  = RST_VAL;
        skid_load       = 1'b0;
        skid_next_valid = 1'b0;
        skid_next_ctrl  = '0;
        skid_next_data  = RST_VAL;

        case (state)
            EMPTY: begin
                if (in_accept) begin
                    main_load       = 1'b1;
                    main_next_valid = 1'b1;
                    main_next_ctrl  = in_ctrl;
                    main_next_data  = in_data;
                    next_state      = ONE;
                end
            end
            ONE: begin
                if (in_accept && out_accept) begin
                    main_load       = 1'b1;
                    main_next_valid = 1'b1;
                    main_next_ctrl  = in_ctrl;
                    main_next_data  = in_data;
                end else if (in_accept) begin
                    skid_load       = 1'b1;
                    skid_next_valid = 1'b1;
                    skid_next_ctrl  = in_ctrl;
                    skid_next_data  = in_data;
                    next_state      = FULL;
                end else if (out_accept) begin
                    main_load  = 1'b1;
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_accept) begin
                    main_load       = 1'b1;
                    main_next_valid = skid_valid;
                    main_next_ctrl  = skid_ctrl;
                    main_next_data  = skid_data;
                    skid_load       = 1'b1;
                    next_state      = ONE;
                end
            end
            default: begin
                main_load  = 1'b1;
                skid_load  = 1'b1;
                next_state = EMPTY;
            end
        endcase

`ifdef PIPE_BUF_FLUSH_EN
        if (flush) begin
            main_load       = 1'b1;
            main_next_valid = 1'b0;
            main_next_ctrl  = '0;
            main_next_data  = RST_VAL;
            skid_load       = 1'b1;
            skid_next_valid = 1'b0;
            skid_next_ctrl  = '0;
            skid_next_data  = RST_VAL;
            next_state      = EMPTY;
        end
`endif
    end

    // State register; in_ready is registered from the next state so it stays low through reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_occupancy(state);

endmodule
